data_mem_ctrl: RTL
==================

Name: data_mem_ctrl

Overview:
Parametrised, clocked data memory for the processor's load/store path. It replaces the combinational word-only memory with the following:
- synchronous byte-lane writes;
- sub-word loads with sign or zero extension;
- a configurable read latency behind a valid/ready request and response handshake;
- error reporting for misaligned and out-of-range accesses.

It sits between the execute/memory stage and the register write-back mux.

Parameters:
ADDR_W, 9, byte-address width; word index = req_addr[ADDR_W-1:2]
DEPTH, 128, number of 32-bit words; must satisfy DEPTH <= 2**(ADDR_W-2)
READ_LAT, 1, cycles from read acceptance to rsp_valid; legal range 1..4

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal
req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend; ignored for stores
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0])
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors
rsp_err  output  1  qualifies rsp_valid: access was misaligned, illegal size or out of range

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=IDLE. Memory array is not reset and its contents are undefined until written.
- Acceptance: a request is accepted on the rising edge where req_valid && req_ready. Only one request is outstanding at a time.
- Handshake: no rsp_ready; the consumer always takes the response.
- Error conditions, evaluated at acceptance:
  - req_size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=00;
  - word index >= DEPTH.
- On error: no memory update. rsp_valid=1 and rsp_err=1 in the cycle after acceptance, with rsp_rdata=0.
- FSM states and transitions:
  - IDLE: req_ready=1. Accepted store or error goes to RESP. Accepted load with READ_LAT=1 goes to RESP; with READ_LAT>1 it goes to WAIT with a counter loaded to READ_LAT-2.
  - WAIT: req_ready=0. Counter decrements each cycle; at 0 the FSM moves to RESP.
  - RESP: rsp_valid=1 for exactly one cycle. req_ready=1, so a new request may be accepted in the same cycle, giving back-to-back throughput. Next state is chosen as from IDLE for the new request, otherwise IDLE.
- Stores: memory is written on the acceptance edge, lanes only.
  - Byte: lane addr[1:0] <= wdata[7:0].
  - Half: lanes {addr[1],0} and {addr[1],1} <= wdata[15:0], little-endian.
  - Word: all four lanes.
  - Untouched lanes are preserved. Ack rsp_valid arrives 1 cycle later with rsp_err=0 and rsp_rdata=0.
- Loads:
  - The word is read on the acceptance edge; lane select and extension are applied per size, addr and unsigned.
  - The result is held in a READ_LAT-deep pipeline. rsp_valid rises exactly READ_LAT cycles after the acceptance edge.
  - A load accepted in the RESP cycle of a prior store observes that store's data.
- Outputs: rsp_rdata and rsp_err hold their last value while rsp_valid=0, and the consumer ignores them then. The verification model treats them as don't-care when rsp_valid=0.
- Reset mid-operation: asserting rst_n=0 in WAIT or RESP aborts the access immediately. No response is issued after release, and a pending load is discarded. Stores already committed persist.
- req_* inputs sampled when req_ready=0 are ignored.

Test Plan:
- Word round-trip: store 0xDEADBEEF @0x010, then load word @0x010 with READ_LAT=3 → store ack 1 cycle after accept; load rsp_valid exactly 3 cycles after accept, rdata=0xDEADBEEF, err=0.
- Byte merge and sign extension:
  - Store word 0x11223344 @0x020, then store byte 0x80 @0x022.
  - Load byte signed @0x022 → 0xFFFFFF80.
  - Load byte unsigned @0x022 → 0x00000080.
  - Load word @0x020 → 0x11803344.
- Half lanes: store half 0xBEEF @0x032, then load half signed @0x032 → 0xFFFFBEEF; load word @0x030 keeps lanes 0-1 at their previous value.
- Errors:
  - Word load @0x011, half store @0x041, and size=11 each → rsp_valid+rsp_err one cycle later, rdata=0.
  - The memory word at the targeted index is unchanged.
  - With DEPTH=64, word index 64 (addr 0x100) → err.
- Back-to-back at READ_LAT=1: req_valid held high for 4 loads → one accept per cycle, four consecutive rsp_valid pulses with correct data; with READ_LAT=2, req_ready is low for exactly 1 cycle per load.
- Reset mid-read: with READ_LAT=4, assert rst_n=0 two cycles after load accept → rsp_valid never asserts for that load; after release req_ready=1 and previously stored data is still readable.

Source files
------------

// File: rtl/data_mem_ctrl_if.sv
// ----------------------------------------------------------------------------
// data_mem_ctrl_if
// Request/response bus between the memory stage and the data memory controller.
//   req_valid    : request present (master -> slave)
//   req_ready    : slave can accept a request this cycle (slave -> master)
//   req_we       : 1 = store, 0 = load
//   req_size     : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned : loads only, 1 = zero-extend, 0 = sign-extend
//   req_addr     : byte address
//   req_wdata    : store data, right-justified
//   rsp_valid    : one-cycle response pulse (slave -> master)
//   rsp_rdata    : extended load result, 0 for stores and errors
//   rsp_err      : qualifies rsp_valid, access was rejected
// ----------------------------------------------------------------------------
interface data_mem_ctrl_if #(
   parameter int ADDR_W = 9
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/data_mem_ctrl.sv
// ----------------------------------------------------------------------------
// data_mem_ctrl
// Clocked data memory for the load/store path: byte-lane stores, sub-word
// loads with sign/zero extension, READ_LAT-cycle load latency behind a
// valid/ready request and a one-cycle response pulse, and error responses
// for misaligned, illegal-size and out-of-range accesses.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : data_mem_ctrl_if.slave (request and response signals)
// ----------------------------------------------------------------------------
module data_mem_ctrl #(
   parameter int ADDR_W   = 9,
   parameter int DEPTH    = 128,
   parameter int READ_LAT = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   data_mem_ctrl_if.slave  bus
);

   localparam int IDX_W  = ADDR_W - 2;
   localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W:0] DEPTH_C  = DEPTH[IDX_W:0];
   localparam logic [1:0]     CNT_INIT = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t             state_r;
   state_t             state_nxt_s;
   logic [1:0]         cnt_r;
   logic               req_ready_s;
   logic               accept_s;
   logic [IDX_W-1:0]   idx_s;
   logic [MEM_AW-1:0]  idx_mem_s;
   logic               size_err_s;
   logic               range_err_s;
   logic               err_s;
   logic [3:0]         be_s;
   logic [31:0]        wlane_s;
   logic [31:0]        rword_s;
   logic [31:0]        load_s;
   logic [31:0]        resp_data_s;
   logic [31:0]        hold_r;
   logic               rsp_valid_r;
   logic [31:0]        rsp_rdata_r;
   logic               rsp_err_r;
   logic [31:0]        mem_r [0:DEPTH-1];

   // Select the addressed lane(s) of a word and extend to 32 bits.
   function automatic logic [31:0] extend_load(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'b00:   b = word[7:0];
         2'b01:   b = word[15:8];
         2'b10:   b = word[23:16];
         default: b = word[31:24];
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      case (size)
         2'b00:   r = {{24{b[7] & ~uns}}, b};
         2'b01:   r = {{16{h[15] & ~uns}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   assign idx_s       = bus.req_addr[ADDR_W-1:2];
   // Upper index bits only matter for the range check; in-range indices fit MEM_AW.
   assign idx_mem_s   = idx_s[MEM_AW-1:0];
   assign range_err_s = ({1'b0, idx_s} >= DEPTH_C);
   assign err_s       = size_err_s | range_err_s;
   assign accept_s    = bus.req_valid & req_ready_s;
   assign rword_s     = mem_r[idx_mem_s];
   assign load_s      = extend_load(rword_s, bus.req_size, bus.req_addr[1:0], bus.req_unsigned);
   assign resp_data_s = (err_s || bus.req_we) ? 32'h0000_0000 : load_s;

   // Decode size/alignment into an error flag, lane enables and replicated store data.
   always_comb begin
      size_err_s = 1'b0;
      be_s       = 4'b0000;
      wlane_s    = bus.req_wdata;
      case (bus.req_size)
         2'b00: begin
            be_s    = 4'b0001 << bus.req_addr[1:0];
            wlane_s = {4{bus.req_wdata[7:0]}};
         end
         2'b01: begin
            size_err_s = bus.req_addr[0];
            be_s       = bus.req_addr[1] ? 4'b1100 : 4'b0011;
            wlane_s    = {2{bus.req_wdata[15:0]}};
         end
         2'b10: begin
            size_err_s = (bus.req_addr[1:0] != 2'b00);
            be_s       = 4'b1111;
         end
         default: begin
            size_err_s = 1'b1;
         end
      endcase
   end

   // State register and wait-cycle counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= 2'd0;
      end else begin
         state_r <= state_nxt_s;
         if (accept_s) begin
            cnt_r <= CNT_INIT;
         end else if (state_r == ST_WAIT && cnt_r != 2'd0) begin
            cnt_r <= cnt_r - 2'd1;
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   // Next-state logic; RESP behaves like IDLE so a new request can follow immediately.
   always_comb begin
      state_nxt_s = ST_IDLE;
      case (state_r)
         ST_IDLE, ST_RESP: begin
            if (accept_s) begin
               if (err_s || bus.req_we || (READ_LAT == 1)) begin
                  state_nxt_s = ST_RESP;
               end else begin
                  state_nxt_s = ST_WAIT;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_r == 2'd0) begin
               state_nxt_s = ST_RESP;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Output decode from state.
   always_comb begin
      req_ready_s = 1'b1;
      if (state_r == ST_WAIT) begin
         req_ready_s = 1'b0;
      end else begin
         req_ready_s = 1'b1;
      end
   end

   // Response registers: loaded only when entering RESP, otherwise held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= 32'h0000_0000;
         rsp_err_r   <= 1'b0;
         hold_r      <= 32'h0000_0000;
      end else begin
         rsp_valid_r <= (state_nxt_s == ST_RESP);
         if (accept_s) begin
            hold_r <= load_s;
         end else begin
            hold_r <= hold_r;
         end
         if (state_nxt_s == ST_RESP) begin
            if (state_r == ST_WAIT) begin
               rsp_rdata_r <= hold_r;
               rsp_err_r   <= 1'b0;
            end else begin
               rsp_rdata_r <= resp_data_s;
               rsp_err_r   <= err_s;
            end
         end else begin
            rsp_rdata_r <= rsp_rdata_r;
            rsp_err_r   <= rsp_err_r;
         end
      end
   end

   // Memory array: byte-lane writes on the acceptance edge, never reset.
   always_ff @(posedge clk) begin
      if (accept_s && bus.req_we && !err_s) begin
         for (int i = 0; i < 4; i++) begin
            if (be_s[i]) begin
               mem_r[idx_mem_s][8*i +: 8] <= wlane_s[8*i +: 8];
            end
         end
      end
   end

   assign bus.req_ready = req_ready_s;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_rdata = rsp_rdata_r;
   assign bus.rsp_err   = rsp_err_r;

endmodule
